axi_test_monitor: RTL and testbench
===================================

AXI_TEST_MONITOR -- requirements
Module: axi_test_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of AXI write-address/write-data channels monitored.
REQ-002 SHALL have parameter ADDR_W, default 32, AWADDR width per channel.
REQ-003 SHALL have parameter DATA_W, default 64, WDATA width per channel.
REQ-004 SHALL have parameter PASS_ADDR, default 32'hFF000000, pass mailbox address.
REQ-005 SHALL have parameter FAIL_ADDR, default 32'hFF001000, fail mailbox address.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 0, run-cycle limit; 0 disables the timeout.
REQ-007 SHALL have port CLK, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port RESETn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port AWVALID, input, NUM_CH, per-channel address valid.
REQ-010 SHALL have port AWREADY, input, NUM_CH, per-channel address ready.
REQ-011 SHALL have port AWADDR, input, NUM_CH x ADDR_W, per-channel address.
REQ-012 SHALL have port WVALID, input, NUM_CH, per-channel write-data valid.
REQ-013 SHALL have port WREADY, input, NUM_CH, per-channel write-data ready.
REQ-014 SHALL have port WDATA, input, NUM_CH x DATA_W, per-channel write data.
REQ-015 SHALL have port DONE, output, 1, test finished (any terminal state).
REQ-016 SHALL have port RESULT, output, 2, 0 none, 1 pass, 2 fail, 3 timeout.
REQ-017 SHALL have port EXIT_CODE, output, 32, low 32 bits of the mailbox write data.
REQ-018 SHALL have port HIT_CH, output, $clog2(NUM_CH) (min 1), channel that terminated the test.
REQ-019 SHALL have port CYCLES, output, 32, cycles since reset release; frozen at DONE.

Function
REQ-020 SHALL be passive: all ports are observation inputs or status outputs; no AXI signal is driven.
REQ-021 SHALL count a hit only on an AW handshake (AWVALID&AWREADY) with AWADDR equal to PASS_ADDR or FAIL_ADDR; valid without ready is ignored.
REQ-022 SHALL implement states RUN, WAIT_W, PASSED, FAILED, TIMEDOUT; reset enters RUN.
REQ-023 In RUN, a hit SHALL latch channel index and kind (pass/fail) and move to WAIT_W on the next edge.
REQ-024 A W handshake on the hit channel in the hit cycle itself SHALL be taken as the mailbox data and go directly to PASSED/FAILED, skipping WAIT_W.
REQ-025 In WAIT_W, the first W handshake on the latched channel SHALL latch WDATA[31:0] into EXIT_CODE and move to PASSED or FAILED; handshakes on other channels are ignored.
REQ-026 Simultaneous hits on several channels SHALL resolve to the lowest channel index.
REQ-027 PASSED, FAILED, TIMEDOUT SHALL be terminal until RESETn asserts; further hits are ignored.
REQ-028 DONE and RESULT SHALL be registered and update one cycle after the deciding handshake edge.
REQ-029 CYCLES SHALL increment each cycle in RUN and WAIT_W, saturate at 32'hFFFFFFFF, and hold in terminal states.
REQ-030 With TIMEOUT_CYC nonzero, CYCLES reaching TIMEOUT_CYC-1 in RUN or WAIT_W SHALL move to TIMEDOUT on that edge; a same-cycle completing handshake takes priority over timeout.
REQ-031 TIMEDOUT SHALL leave EXIT_CODE at 0 and HIT_CH at the latched value (0 if no hit).

Reset
REQ-032 On RESETn low: state RUN, DONE 0, RESULT 0, EXIT_CODE 0, HIT_CH 0, CYCLES 0, asynchronously.
REQ-033 RESETn asserted mid-WAIT_W SHALL discard the pending hit; monitoring resumes from RUN on release.

Structure
REQ-034 Result encoding, state enum and default mailbox addresses SHALL live in shared package axi_test_monitor_pkg.
REQ-035 A sub-module axi_hit_arbiter (fixed-priority, lowest index, one-hot to binary) SHALL select the hit channel.
REQ-036 Testbench wrappers SHALL print "TEST : PASS"/"TEST : FAIL"/"TEST : TIMEOUT" and call $finish from DONE, outside this block.

Verification
REQ-037 AW handshake ch1 addr FF000000, W ch1 data 0x2A two cycles later -> DONE=1, RESULT=1, EXIT_CODE=0x2A, HIT_CH=1.
REQ-038 AWVALID ch0 addr FF001000 with AWREADY=0 for 10 cycles -> DONE stays 0; then handshake plus same-cycle W data 0x5 -> RESULT=2, EXIT_CODE=5 next cycle.
REQ-039 Same-cycle hits ch0 FF001000 and ch1 FF000000 -> HIT_CH=0, RESULT=2 after ch0 W beat; ch1 W beat ignored.
REQ-040 TIMEOUT_CYC=100, no hits -> DONE=1, RESULT=3 when CYCLES=100 after reset release, CYCLES frozen thereafter.
REQ-041 Hit on ch0, RESETn pulsed low before W beat -> all outputs 0; later ch0 W beat without AW hit leaves DONE=0.
REQ-042 After PASSED, a second hit at FF001000 -> RESULT remains 1, EXIT_CODE unchanged.

Source files
------------

// File: rtl/axi_test_monitor_pkg.sv
// Shared types for the AXI test-completion monitor: result codes, FSM states, mailbox addresses.
// Latency: none, declarations and pure helper functions only.
// Backpressure: not applicable.
package axi_test_monitor_pkg;

    // Encoding presented on RESULT
    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_e;

    // Monitor FSM states; the last three are terminal until reset
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_WAIT_W   = 3'd1,
        ST_PASSED   = 3'd2,
        ST_FAILED   = 3'd3,
        ST_TIMEDOUT = 3'd4
    } state_e;

    localparam logic [31:0] DEF_PASS_ADDR = 32'hFF00_0000;
    localparam logic [31:0] DEF_FAIL_ADDR = 32'hFF00_1000;

    // Map the latched mailbox kind onto the result code
    function automatic result_e kind_result(input logic is_fail);
        return is_fail ? RES_FAIL : RES_PASS;
    endfunction

    // Cycle counter increment that sticks at all-ones
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axi_hit_arbiter.sv
// Fixed-priority arbiter: picks the lowest-index asserted request and encodes it as binary.
// Latency: purely combinational.
// Backpressure: none, requests are observations and are never stalled.
module axi_hit_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest asserted index is the last writer
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_test_monitor.sv
// Passive AXI write snooper: detects pass/fail mailbox writes, captures exit code, optional run timeout.
// Latency: DONE/RESULT/EXIT_CODE register one cycle after the deciding handshake edge.
// Backpressure: none; never drives AXI, only observes VALID&READY handshakes.
module axi_test_monitor
    import axi_test_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 64,
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] FAIL_ADDR   = DEF_FAIL_ADDR,
    parameter int unsigned TIMEOUT_CYC = 0,
    localparam int unsigned HIT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           CLK,
    input  logic                           RESETn,
    input  logic [NUM_CH-1:0]              AWVALID,
    input  logic [NUM_CH-1:0]              AWREADY,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  AWADDR,
    input  logic [NUM_CH-1:0]              WVALID,
    input  logic [NUM_CH-1:0]              WREADY,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  WDATA,
    output logic                           DONE,
    output logic [1:0]                     RESULT,
    output logic [31:0]                    EXIT_CODE,
    output logic [HIT_W-1:0]               HIT_CH,
    output logic [31:0]                    CYCLES
);

    state_e            state_q;
    logic              done_q;
    result_e           result_q;
    logic [31:0]       exit_q;
    logic [HIT_W-1:0]  hit_ch_q;
    logic              hit_fail_q;
    logic [31:0]       cycles_q;

    logic [NUM_CH-1:0] hit_vec;
    logic [NUM_CH-1:0] w_hs;
    logic              arb_any;
    logic [HIT_W-1:0]  arb_idx;
    logic              arb_is_fail;
    logic              timeout_now;

    // Per-channel mailbox hits (AW handshake to either mailbox) and W handshakes
    always_comb begin
        hit_vec = '0;
        w_hs    = WVALID & WREADY;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit_vec[i] = AWVALID[i] & AWREADY[i] &
                         ((AWADDR[i] == ADDR_W'(PASS_ADDR)) || (AWADDR[i] == ADDR_W'(FAIL_ADDR)));
        end
    end

    axi_hit_arbiter #(
        .N     (NUM_CH),
        .IDX_W (HIT_W)
    ) u_arb (
        .req_i (hit_vec),
        .any_o (arb_any),
        .idx_o (arb_idx)
    );

    // Kind of the winning hit and the timeout condition for this cycle
    always_comb begin
        arb_is_fail = (AWADDR[arb_idx] == ADDR_W'(FAIL_ADDR));
        timeout_now = (TIMEOUT_CYC != 0) && (cycles_q == 32'(TIMEOUT_CYC - 1));
    end

    // Monitor FSM; all status outputs are registered here. A completing W
    // handshake beats a timeout that lands on the same edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_RUN;
            done_q     <= 1'b0;
            result_q   <= RES_NONE;
            exit_q     <= '0;
            hit_ch_q   <= '0;
            hit_fail_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycles_q <= sat_inc(cycles_q);
                    if (arb_any && w_hs[arb_idx]) begin
                        state_q  <= arb_is_fail ? ST_FAILED : ST_PASSED;
                        done_q   <= 1'b1;
                        result_q <= kind_result(arb_is_fail);
                        exit_q   <= 32'(WDATA[arb_idx]);
                        hit_ch_q <= arb_idx;
                    end else if (timeout_now) begin
                        state_q  <= ST_TIMEDOUT;
                        done_q   <= 1'b1;
                        result_q <= RES_TIMEOUT;
                    end else if (arb_any) begin
                        state_q    <= ST_WAIT_W;
                        hit_ch_q   <= arb_idx;
                        hit_fail_q <= arb_is_fail;
                    end
                end
                ST_WAIT_W: begin
                    cycles_q <= sat_inc(cycles_q);
                    if (w_hs[hit_ch_q]) begin
                        state_q  <= hit_fail_q ? ST_FAILED : ST_PASSED;
                        done_q   <= 1'b1;
                        result_q <= kind_result(hit_fail_q);
                        exit_q   <= 32'(WDATA[hit_ch_q]);
                    end else if (timeout_now) begin
                        state_q  <= ST_TIMEDOUT;
                        done_q   <= 1'b1;
                        result_q <= RES_TIMEOUT;
                    end
                end
                default: begin
                    // Terminal: everything frozen until reset
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign EXIT_CODE = exit_q;
    assign HIT_CH    = hit_ch_q;
    assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_axi_test_monitor.sv
// Directed bench for axi_test_monitor (two channels, 100-cycle timeout).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: AWREADY/WREADY driven directly by the stimulus.
module tb_axi_test_monitor;

    logic             CLK;
    logic             RESETn;
    logic [1:0]       AWVALID;
    logic [1:0]       AWREADY;
    logic [1:0][31:0] AWADDR;
    logic [1:0]       WVALID;
    logic [1:0]       WREADY;
    logic [1:0][63:0] WDATA;
    logic             DONE;
    logic [1:0]       RESULT;
    logic [31:0]      EXIT_CODE;
    logic [0:0]       HIT_CH;
    logic [31:0]      CYCLES;

    int total;
    int bad;

    axi_test_monitor #(
        .NUM_CH      (2),
        .ADDR_W      (32),
        .DATA_W      (64),
        .PASS_ADDR   (32'hFF00_0000),
        .FAIL_ADDR   (32'hFF00_1000),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .EXIT_CODE (EXIT_CODE),
        .HIT_CH    (HIT_CH),
        .CYCLES    (CYCLES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        AWVALID = '0;
        AWREADY = '0;
        AWADDR  = '0;
        WVALID  = '0;
        WREADY  = '0;
        WDATA   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".done"},   64'(DONE),      64'd0);
        chk({tag, ".result"}, 64'(RESULT),    64'd0);
        chk({tag, ".exit"},   64'(EXIT_CODE), 64'd0);
        chk({tag, ".hit"},    64'(HIT_CH),    64'd0);
        chk({tag, ".cycles"}, 64'(CYCLES),    64'd0);
    endtask

    // Hold reset for two edges, check the reset values, release between edges
    task automatic do_reset(input string tag);
        idle_inputs();
        RESETn = 1'b0;
        tick(2);
        check_all_zero(tag);
        RESETn = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        RESETn = 1'b0;
        idle_inputs();
        #3;

        // Pass mailbox on ch1, W beat two cycles after the AW handshake
        do_reset("rst1");
        AWVALID = 2'b10; AWREADY = 2'b10; AWADDR[1] = 32'hFF00_0000;
        tick(1);
        chk("pass.aw_done", 64'(DONE),   64'd0);
        chk("pass.aw_hit",  64'(HIT_CH), 64'd1);
        idle_inputs();
        tick(1);
        chk("pass.wait_done", 64'(DONE), 64'd0);
        WVALID = 2'b10; WREADY = 2'b10; WDATA[1] = 64'h2A;
        tick(1);
        idle_inputs();
        chk("pass.done",   64'(DONE),      64'd1);
        chk("pass.result", 64'(RESULT),    64'd1);
        chk("pass.exit",   64'(EXIT_CODE), 64'h2A);
        chk("pass.hit",    64'(HIT_CH),    64'd1);
        chk("pass.cycles", 64'(CYCLES),    64'd3);

        // Second hit after PASSED must be ignored, counter frozen
        AWVALID = 2'b01; AWREADY = 2'b01; AWADDR[0] = 32'hFF00_1000;
        WVALID  = 2'b01; WREADY  = 2'b01; WDATA[0]  = 64'h99;
        tick(1);
        idle_inputs();
        tick(2);
        chk("post.result", 64'(RESULT),    64'd1);
        chk("post.exit",   64'(EXIT_CODE), 64'h2A);
        chk("post.hit",    64'(HIT_CH),    64'd1);
        chk("post.cycles", 64'(CYCLES),    64'd3);

        // Fail mailbox: valid without ready is not a hit, then same-cycle AW+W
        do_reset("rst2");
        AWVALID = 2'b01; AWREADY = 2'b00; AWADDR[0] = 32'hFF00_1000;
        tick(10);
        chk("noready.done", 64'(DONE), 64'd0);
        AWREADY = 2'b01;
        WVALID  = 2'b01; WREADY = 2'b01; WDATA[0] = 64'h5;
        tick(1);
        idle_inputs();
        chk("fail.done",   64'(DONE),      64'd1);
        chk("fail.result", 64'(RESULT),    64'd2);
        chk("fail.exit",   64'(EXIT_CODE), 64'h5);
        chk("fail.hit",    64'(HIT_CH),    64'd0);
        chk("fail.cycles", 64'(CYCLES),    64'd11);

        // Simultaneous hits resolve to ch0; a W beat on ch1 is ignored
        do_reset("rst3");
        AWVALID = 2'b11; AWREADY = 2'b11;
        AWADDR[0] = 32'hFF00_1000; AWADDR[1] = 32'hFF00_0000;
        tick(1);
        idle_inputs();
        chk("arb.hit", 64'(HIT_CH), 64'd0);
        WVALID = 2'b10; WREADY = 2'b10; WDATA[1] = 64'h77;
        tick(1);
        idle_inputs();
        chk("arb.ch1_ignored", 64'(DONE), 64'd0);
        WVALID = 2'b01; WREADY = 2'b01; WDATA[0] = 64'h1234_5678_9ABC_DEF0;
        tick(1);
        idle_inputs();
        chk("arb.done",   64'(DONE),      64'd1);
        chk("arb.result", 64'(RESULT),    64'd2);
        chk("arb.exit",   64'(EXIT_CODE), 64'h9ABC_DEF0);
        chk("arb.hit2",   64'(HIT_CH),    64'd0);

        // Non-mailbox address and W without a pending hit are both ignored
        do_reset("rst4");
        AWVALID = 2'b01; AWREADY = 2'b01; AWADDR[0] = 32'hFF00_0004;
        WVALID  = 2'b01; WREADY  = 2'b01; WDATA[0]  = 64'h3;
        tick(2);
        idle_inputs();
        chk("miss.done",   64'(DONE),   64'd0);
        chk("miss.result", 64'(RESULT), 64'd0);
        chk("miss.cycles", 64'(CYCLES), 64'd2);

        // Reset in WAIT_W discards the hit
        do_reset("rst5");
        AWVALID = 2'b01; AWREADY = 2'b01; AWADDR[0] = 32'hFF00_0000;
        tick(1);
        idle_inputs();
        #2;
        RESETn = 1'b0;
        #1;
        check_all_zero("midrst");
        #1;
        RESETn = 1'b1;
        WVALID = 2'b01; WREADY = 2'b01; WDATA[0] = 64'h9;
        tick(1);
        idle_inputs();
        tick(1);
        chk("midrst.done",   64'(DONE),      64'd0);
        chk("midrst.result", 64'(RESULT),    64'd0);
        chk("midrst.exit",   64'(EXIT_CODE), 64'd0);
        chk("midrst.cycles", 64'(CYCLES),    64'd2);

        // Timeout with no hits: fires when CYCLES reaches 100, then freezes
        do_reset("rst6");
        tick(99);
        chk("to.before_done",   64'(DONE),   64'd0);
        chk("to.before_cycles", 64'(CYCLES), 64'd99);
        tick(1);
        chk("to.done",   64'(DONE),      64'd1);
        chk("to.result", 64'(RESULT),    64'd3);
        chk("to.cycles", 64'(CYCLES),    64'd100);
        chk("to.exit",   64'(EXIT_CODE), 64'd0);
        chk("to.hit",    64'(HIT_CH),    64'd0);
        AWVALID = 2'b01; AWREADY = 2'b01; AWADDR[0] = 32'hFF00_0000;
        WVALID  = 2'b01; WREADY  = 2'b01; WDATA[0]  = 64'h1;
        tick(5);
        idle_inputs();
        chk("to.frozen_cycles", 64'(CYCLES), 64'd100);
        chk("to.frozen_result", 64'(RESULT), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
